// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART widths and FIFO operation encoding used by the receive-side byte buffer.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W = 8;
    localparam int FIFO_ADDR_W = 4;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// 2**ADDR_W x DATA_W register array with one synchronous write port and one
// synchronous read port; contents are deliberately not reset.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Write and read ports; a same-address write/read returns the old entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side circular byte FIFO: accepts bytes from the UART receiver, acks each
// with rxuld, and delivers them to the host on rden with one-cycle read latency.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              rxclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rxrcvd,
    input  logic              rxdv,
    output logic              rxuld,
    input  logic              rden,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    input  logic              ovfclr
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              rxuld_q, rxuld_d;
    logic              rvalid_q, rvalid_d;
    logic              ovf_q, ovf_d;
    logic              rd_any_q, rd_any_d;
    logic              push_ok, pop_ok;
    fifo_op_e          op;
    logic [DATA_W-1:0] mem_rdata;

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (rxclk),
        .we    (push_ok),
        .waddr (wptr_q[ADDR_W-1:0]),
        .wdata (rxrcvd),
        .re    (pop_ok),
        .raddr (rptr_q[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    // Next-state for pointers, occupancy flags, handshakes and sticky overflow.
    always_comb begin
        pop_ok  = rden && !empty_q;
        // A full FIFO still takes a byte when a pop frees a slot in the same cycle.
        push_ok = rxdv && (!full_q || pop_ok);
        op      = fifo_op(push_ok, pop_ok);

        if (push_ok) begin
            wptr_d = wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (pop_ok) begin
            rptr_d = rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end

        case (op)
            OP_PUSH: count_d = count_q + PTR_W'(1);
            OP_POP:  count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase

        empty_d  = (wptr_d == rptr_d);
        full_d   = (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]) &&
                   (wptr_d[ADDR_W] != rptr_d[ADDR_W]);
        rxuld_d  = rxdv;
        rvalid_d = pop_ok;
        rd_any_d = rd_any_q || pop_ok;

        if (rxdv && !push_ok) begin
            ovf_d = 1'b1;
        end else if (ovfclr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers, all cleared asynchronously by reset.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            wptr_q   <= {PTR_W{1'b0}};
            rptr_q   <= {PTR_W{1'b0}};
            count_q  <= {PTR_W{1'b0}};
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            rxuld_q  <= 1'b0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            rd_any_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            rxuld_q  <= rxuld_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            rd_any_q <= rd_any_d;
        end
    end

    // The memory read register has no reset, so rdata reads zero until the first pop.
    always_comb begin
        if (rd_any_q) begin
            rdata = mem_rdata;
        end else begin
            rdata = {DATA_W{1'b0}};
        end
    end

    assign rxuld  = rxuld_q;
    assign rvalid = rvalid_q;
    assign empty  = empty_q;
    assign full   = full_q;
    assign count  = count_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: reference queue model plus a scoreboard of
// expected popped bytes, a short table of hand-computed vectors, and corner sequences.
module tb_uart_rx_fifo;

    logic       rxclk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rxrcvd = 8'h00;
    logic       rxdv = 1'b0;
    logic       rden = 1'b0;
    logic       ovfclr = 1'b0;
    logic       rxuld, rvalid, empty, full, ovf;
    logic [7:0] rdata;
    logic [4:0] count;

    uart_rx_fifo dut (
        .rxclk  (rxclk),
        .reset  (reset),
        .rxrcvd (rxrcvd),
        .rxdv   (rxdv),
        .rxuld  (rxuld),
        .rden   (rden),
        .rdata  (rdata),
        .rvalid (rvalid),
        .empty  (empty),
        .full   (full),
        .count  (count),
        .ovf    (ovf),
        .ovfclr (ovfclr)
    );

    always #5 rxclk = ~rxclk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] ref_q[$];
    logic [7:0] sb_q[$];
    logic       m_ovf = 1'b0;
    logic [7:0] last_rdata = 8'h00;

    typedef struct {
        logic       dv;
        logic [7:0] d;
        logic       rd;
        logic       e_rvalid;
        logic [7:0] e_rdata;
        int         e_count;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model predicts every output and the scoreboard
    // supplies the byte expected from each accepted pop.
    task automatic step(input logic dv, input logic [7:0] d, input logic rd, input logic clr);
        bit         m_full, m_empty, pop_ok, push_ok;
        logic [7:0] exp_b;
        rxdv = dv; rxrcvd = d; rden = rd; ovfclr = clr;
        m_full  = (ref_q.size() == 16);
        m_empty = (ref_q.size() == 0);
        pop_ok  = rd && !m_empty;
        push_ok = dv && (!m_full || pop_ok);
        if (pop_ok) sb_q.push_back(ref_q[0]);
        @(posedge rxclk);
        if (pop_ok) void'(ref_q.pop_front());
        if (push_ok) ref_q.push_back(d);
        if (dv && !push_ok) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        rxdv = 1'b0; rden = 1'b0; ovfclr = 1'b0;
        chk("rxuld", int'(rxuld), int'(dv));
        chk("rvalid", int'(rvalid), int'(pop_ok));
        chk("count", int'(count), ref_q.size());
        chk("empty", int'(empty), int'(ref_q.size() == 0));
        chk("full", int'(full), int'(ref_q.size() == 16));
        chk("ovf", int'(ovf), int'(m_ovf));
        if (pop_ok) begin
            exp_b = sb_q.pop_front();
            chk("rdata", int'(rdata), int'(exp_b));
            last_rdata = exp_b;
        end else begin
            chk("rdata_hold", int'(rdata), int'(last_rdata));
        end
    endtask

    initial begin
        // push 41,42,43; pop three; then push+pop on empty and a follow-up pop
        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1};
        tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 2};
        tbl[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 8'h00, 3};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 2};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h43, 0};
        tbl[6] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 0};

        repeat (3) @(negedge rxclk);
        reset = 1'b0;

        // Idle after reset release
        repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_rdata", int'(rdata), 0);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].dv, tbl[i].d, tbl[i].rd, 1'b0);
            chk($sformatf("tbl%0d_rvalid", i), int'(rvalid), int'(tbl[i].e_rvalid));
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_count);
            if (tbl[i].e_rvalid) chk($sformatf("tbl%0d_rdata", i), int'(rdata), int'(tbl[i].e_rdata));
        end
        chk("tbl_empty", int'(empty), 1);

        // Fill to 16, overflow with 0xFF, drain, clear ovf
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full", int'(full), 1);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_count", int'(count), 16);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("drain%0d", i), int'(rdata), i);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("no_ff_rvalid", int'(rvalid), 0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", int'(ovf), 0);

        // Full FIFO, push 0xAA with simultaneous pop
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("both_full_rdata", int'(rdata), 8'h10);
        chk("both_full_count", int'(count), 16);
        chk("both_full_ovf", int'(ovf), 0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("aa_last", int'(rdata), 8'hAA);

        // 3 pushes per 2 pops, wrapping the pointers
        for (int b = 0; b < 14; b++) begin
            for (int w = 0; w < 3; w++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            for (int r = 0; r < 2; r++) step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        step(1'b1, 8'h99, 1'b1, 1'b0);

        // Asynchronous reset mid-stream with rxuld and rvalid both high
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_full", int'(full), 0);
        chk("arst_rvalid", int'(rvalid), 0);
        chk("arst_rxuld", int'(rxuld), 0);
        chk("arst_rdata", int'(rdata), 0);
        ref_q.delete();
        sb_q.delete();
        m_ovf = 1'b0;
        last_rdata = 8'h00;
        repeat (2) @(negedge rxclk);
        reset = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_no_stale", int'(rvalid), 0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_byte", int'(rdata), 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
